// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU control codes, major opcodes and the
// decoded-control record passed from the decoder into the ID/EX register.
package core_pkg;

  // ALU control codes consumed by the ALU ctrl input.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_BLT  = 4'b1000;
  localparam logic [3:0] ALU_BGE  = 4'b1001;
  localparam logic [3:0] ALU_BLTU = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;
  localparam logic [3:0] ALU_BEQ  = 4'b1100;
  localparam logic [3:0] ALU_BNE  = 4'b1101;

  // Major opcodes (instr[6:0]) handled by this core.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Source of ALU operand 0.
  typedef enum logic [1:0] {
    SRC0_RS1  = 2'd0,
    SRC0_ZERO = 2'd1,
    SRC0_PC   = 2'd2
  } src0_e;

  // Source of ALU operand 1.
  typedef enum logic {
    SRC1_RS2 = 1'b0,
    SRC1_IMM = 1'b1
  } src1_e;

  // Everything the EX stage needs to know about an instruction's class.
  typedef struct packed {
    logic [3:0] ctrl;
    src0_e      src0;
    src1_e      src1;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       is_branch;
    logic       illegal;
    logic       uses_rs2;
  } dec_t;

  // Arithmetic/logic funct3 mapping shared by R and I-ALU formats.
  // Returns {legal, ctrl}. alt is instr[30]; sub_ok is 0 for I-ALU, where
  // funct3 000 is always ADD (ADDI has no subtract form).
  function automatic logic [4:0] alu_op(input logic [2:0] f3,
                                        input logic       alt,
                                        input logic       sub_ok);
    logic [4:0] r;
    case (f3)
      3'b000:  r = {1'b1, (sub_ok && alt) ? ALU_SUB : ALU_ADD};
      3'b001:  r = {1'b1, ALU_SLL};
      3'b100:  r = {1'b1, ALU_XOR};
      3'b101:  r = {1'b1, alt ? ALU_SRA : ALU_SRL};
      3'b110:  r = {1'b1, ALU_OR};
      3'b111:  r = {1'b1, ALU_AND};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction classifier: maps a raw RV32I instruction to the
// ALU control code, operand selects, side-effect bits and an illegal flag.
module alu_ctrl_decode
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       alt;
  logic [4:0] arith;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign alt    = instr[30];
  assign arith  = alu_op(f3, alt, opcode == OP_R);

  // Register fields and most immediate bits are consumed elsewhere.
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify by opcode, then squash all side effects of illegal encodings.
  always_comb begin
    dec           = '0;
    dec.ctrl      = ALU_ADD;
    dec.src0      = SRC0_RS1;
    dec.src1      = SRC1_RS2;
    case (opcode)
      OP_R: begin
        dec.ctrl     = arith[3:0];
        dec.illegal  = !arith[4];
        dec.regwrite = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec.ctrl     = arith[3:0];
        dec.illegal  = !arith[4];
        dec.regwrite = 1'b1;
        dec.src1     = SRC1_IMM;
      end
      OP_LOAD: begin
        dec.src1     = SRC1_IMM;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
      end
      OP_STORE: begin
        dec.src1     = SRC1_IMM;
        dec.memwrite = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.uses_rs2  = 1'b1;
        case (f3)
          3'b000:  dec.ctrl = ALU_BEQ;
          3'b001:  dec.ctrl = ALU_BNE;
          3'b100:  dec.ctrl = ALU_BLT;
          3'b101:  dec.ctrl = ALU_BGE;
          3'b110:  dec.ctrl = ALU_BLTU;
          3'b111:  dec.ctrl = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec.src0     = SRC0_ZERO;
        dec.src1     = SRC1_IMM;
        dec.regwrite = 1'b1;
      end
      OP_AUIPC: begin
        dec.src0     = SRC0_PC;
        dec.src1     = SRC1_IMM;
        dec.regwrite = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.ctrl      = ALU_ADD;
      dec.regwrite  = 1'b0;
      dec.memread   = 1'b0;
      dec.memwrite  = 1'b0;
      dec.is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers one decoded instruction per cycle, drives
// the ALU operands with EX/MEM and MEM/WB forwarding, and stalls ID for one
// cycle on a load-use hazard by inserting a bubble.
//
// Handshake: an instruction moves from ID into EX on a rising edge exactly
// when id_valid && id_ready && !flush. id_ready depends only on the current
// EX slot and the presented instruction, never on id_valid or flush.
module id_ex_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        flush,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_regwrite,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic [3:0]  ex_ctrl,
  output logic [31:0] ex_data0,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_branch_target,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_is_branch,
  output logic        ex_illegal
);

  dec_t        id_dec;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        load_use;
  logic        capture;

  // EX-slot state not visible directly on the ports.
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  src0_e       ex_src0;
  src1_e       ex_src1;

  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  alu_ctrl_decode u_dec (
    .instr (id_instr),
    .dec   (id_dec)
  );

  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];

  // A load in EX whose destination feeds the ID instruction cannot forward
  // in time; hold ID for one cycle. The bubble clears ex_memread, so the
  // stall never lasts longer than that.
  assign load_use = ex_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_dec.uses_rs2 && (ex_rd == id_rs2)));
  assign id_ready = !load_use;
  assign capture  = id_valid && !load_use && !flush;

  // Pipeline register: capture the ID instruction or load a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || !capture) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= 4'b0000;
      ex_pc        <= 32'd0;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_is_branch <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_imm       <= 32'd0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rs1_data  <= 32'd0;
      ex_rs2_data  <= 32'd0;
      ex_src0      <= SRC0_RS1;
      ex_src1      <= SRC1_RS2;
    end else begin
      ex_valid     <= 1'b1;
      ex_ctrl      <= id_dec.ctrl;
      ex_pc        <= id_pc;
      ex_rd        <= id_instr[11:7];
      ex_funct3    <= id_instr[14:12];
      ex_regwrite  <= id_dec.regwrite;
      ex_memread   <= id_dec.memread;
      ex_memwrite  <= id_dec.memwrite;
      ex_is_branch <= id_dec.is_branch;
      ex_illegal   <= id_dec.illegal;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_src0      <= id_dec.src0;
      ex_src1      <= id_dec.src1;
    end
  end

  // Forwarding: newest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (exmem_regwrite && (exmem_rd == ex_rs1) && (ex_rs1 != 5'd0))
      fwd_rs1 = exmem_result;
    else if (memwb_regwrite && (memwb_rd == ex_rs1) && (ex_rs1 != 5'd0))
      fwd_rs1 = memwb_result;
    fwd_rs2 = ex_rs2_data;
    if (exmem_regwrite && (exmem_rd == ex_rs2) && (ex_rs2 != 5'd0))
      fwd_rs2 = exmem_result;
    else if (memwb_regwrite && (memwb_rd == ex_rs2) && (ex_rs2 != 5'd0))
      fwd_rs2 = memwb_result;
  end

  // ALU operand selection from the forwarded register values.
  always_comb begin
    case (ex_src0)
      SRC0_ZERO: ex_data0 = 32'd0;
      SRC0_PC:   ex_data0 = ex_pc;
      default:   ex_data0 = fwd_rs1;
    endcase
    ex_data1 = (ex_src1 == SRC1_IMM) ? ex_imm : fwd_rs2;
  end

  assign ex_store_data    = fwd_rs2;
  assign ex_branch_target = ex_pc + ex_imm;

endmodule
